hexss_scan_ctrl: RTL

//   Time-multiplexed scan controller that shares one hexss 7-segment decoder

---
 rtl/hexss_pkg.sv | 20 ++
 rtl/hexss_lzs_mask.sv | 22 ++
 rtl/hexss_scan_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hexss_pkg.sv
// Shared types and helpers for the hexss multiplexed display scan controller.
// Widths are sized for the largest supported digit count and slot length.
package hexss_pkg;

    localparam int MAX_DIGITS = 32;
    localparam int IDX_W      = 5;
    localparam int CNT_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    // Callers truncate the result to their own digit count.
    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/hexss_lzs_mask.sv
// Leading-zero suppression mask: bit i set when digit i and every digit above it
// hold zero. Digit 0 is never suppressed, so only the upper nibbles come in.
module hexss_lzs_mask #(
    parameter int NDIGITS = 4
) (
    input  logic [4*(NDIGITS-1)-1:0] upper,
    input  logic                     lzs_en,
    output logic [NDIGITS-1:0]       mask
);
    logic zero_run_s;

    // Walk from the most significant digit down, tracking an unbroken run of zeros.
    always_comb begin
        zero_run_s = 1'b1;
        mask       = '0;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s & (upper[4*(i-1) +: 4] == 4'h0);
            mask[i]    = lzs_en & zero_run_s;
        end
    end

endmodule

// File: rtl/hexss_scan_ctrl.sv
// Time-multiplexed scan controller feeding one shared hexss decoder.
// All outputs decode from registered state, so no input reaches an output combinationally.
module hexss_scan_ctrl
    import hexss_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   load,
    input  logic                   enable,
    input  logic                   lamp_test,
    input  logic                   lzs_en,
    output logic [3:0]             hexin,
    output logic                   darkN,
    output logic                   LampTest,
    output logic [NDIGITS-1:0]     digit_sel,
    output logic                   frame_tick
);
    scan_state_t            state_r, state_n_s;
    logic [IDX_W-1:0]       idx_r, idx_n_s, idx_inc_s;
    logic [CNT_W-1:0]       cnt_r, cnt_n_s;
    logic [4*NDIGITS-1:0]   shadow_r;
    logic                   lamp_r, lzs_r;
    logic [NDIGITS-1:0]     sel_s, mask_s;
    logic                   last_idx_s;

    hexss_lzs_mask #(.NDIGITS(NDIGITS)) u_lzs (
        .upper  (shadow_r[4*NDIGITS-1:4]),
        .lzs_en (lzs_r),
        .mask   (mask_s)
    );

    assign last_idx_s = (idx_r == IDX_W'(NDIGITS - 1));
    assign idx_inc_s  = last_idx_s ? '0 : idx_r + IDX_W'(1);
    assign sel_s      = NDIGITS'(onehot(idx_r));

    // Scan state, digit index and slot counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n_s;
            idx_r   <= idx_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Shadow value and per-cycle samples of the display controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= '0;
            lamp_r   <= 1'b0;
            lzs_r    <= 1'b0;
        end else begin
            if (load) begin
                shadow_r <= value;
            end else begin
                shadow_r <= shadow_r;
            end
            lamp_r <= lamp_test;
            lzs_r  <= lzs_en;
        end
    end

    // Next-state logic; dropping enable always returns to a clean IDLE.
    always_comb begin
        state_n_s = state_r;
        idx_n_s   = idx_r;
        cnt_n_s   = cnt_r;
        if (!enable) begin
            state_n_s = IDLE;
            idx_n_s   = '0;
            cnt_n_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n_s = SHOW;
                    idx_n_s   = '0;
                    cnt_n_s   = '0;
                end
                SHOW: begin
                    if (cnt_r == CNT_W'(SHOW_CYCLES - 1)) begin
                        cnt_n_s = '0;
                        if (BLANK_CYCLES == 0) begin
                            idx_n_s = idx_inc_s;
                        end else begin
                            state_n_s = BLANK;
                        end
                    end else begin
                        cnt_n_s = cnt_r + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (cnt_r == CNT_W'(BLANK_CYCLES - 1)) begin
                        state_n_s = SHOW;
                        idx_n_s   = idx_inc_s;
                        cnt_n_s   = '0;
                    end else begin
                        cnt_n_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_n_s = IDLE;
                    idx_n_s   = '0;
                    cnt_n_s   = '0;
                end
            endcase
        end
    end

    // Decoder feed and digit strobes; lamp test overrides suppression.
    always_comb begin
        hexin     = 4'h0;
        darkN     = 1'b0;
        LampTest  = 1'b0;
        digit_sel = '0;
        if (state_r == SHOW) begin
            digit_sel = sel_s;
            for (int i = 0; i < NDIGITS; i++) begin
                hexin = hexin | ({4{sel_s[i]}} & shadow_r[4*i +: 4]);
            end
            if (lamp_r) begin
                darkN    = 1'b1;
                LampTest = 1'b1;
            end else if (|(sel_s & mask_s)) begin
                darkN    = 1'b0;
                LampTest = 1'b0;
            end else begin
                darkN    = 1'b1;
                LampTest = 1'b0;
            end
        end else begin
            digit_sel = '0;
        end
    end

    // Pulse on the final cycle of the last digit's slot, i.e. the index wrap.
    always_comb begin
        if (BLANK_CYCLES == 0) begin
            frame_tick = (state_r == SHOW) && last_idx_s && (cnt_r == CNT_W'(SHOW_CYCLES - 1));
        end else begin
            frame_tick = (state_r == BLANK) && last_idx_s && (cnt_r == CNT_W'(BLANK_CYCLES - 1));
        end
    end

endmodule
